// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its surroundings (controls,
// instruction memory port, latched-instruction outputs).
// The breakpoint signals exist only when FETCH_BREAK_EN is defined.
//
// Strobe semantics: there is no back-pressure on this bus. inst_valid is
// a one-cycle pulse that marks the cycle in which a fetch completes.
// pc/inst take the completed fetch's values at the end of that cycle and
// then hold them until the next completed fetch. mem_en qualifies
// mem_addr, and mem_addr is stable for as long as mem_en is high.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              run;
  logic              step;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              busy;
`ifdef FETCH_BREAK_EN
  logic [ADDR_W-1:0] brk_addr;
  logic              brk_en;
  logic              halted;

  modport master (
    input  run, step, mem_data, brk_addr, brk_en,
    output mem_en, mem_addr, pc, inst, inst_valid, busy, halted
  );
  modport slave (
    output run, step, mem_data, brk_addr, brk_en,
    input  mem_en, mem_addr, pc, inst, inst_valid, busy, halted
  );
`else
  modport master (
    input  run, step, mem_data,
    output mem_en, mem_addr, pc, inst, inst_valid, busy
  );
  modport slave (
    output run, step, mem_data,
    input  mem_en, mem_addr, pc, inst, inst_valid, busy
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: programmable auto-step rate, run/pause with
// single-step, ROM latency wait states and address wrap at MEM_DEPTH words.
// Optional macro FETCH_BREAK_EN adds a single address breakpoint that halts
// auto-stepping until the next step pulse.
// dbg_state exposes the FSM state (0 IDLE, 1 WAIT, 2 LATCH).
module fetch_sequencer #(
  parameter int CLK_DIV   = 100000000,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam int                TW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_MAX  = TW'(CLK_DIV - 1);
  localparam logic [1:0]        LAT_INIT  = 2'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] WRAP_ADDR = ADDR_W'(MEM_DEPTH * 4);

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic              trigger;
  logic              fetched;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] inst_q;

  assign tick = bus.run && (tick_cnt == TICK_MAX);

`ifdef FETCH_BREAK_EN
  logic halted_q;
  // While halted only a step pulse can start a fetch, even with run high.
  assign trigger = halted_q ? bus.step : (bus.run ? tick : bus.step);
`else
  // run selects the trigger source, so a step pulse during run is ignored.
  assign trigger = bus.run ? tick : bus.step;
`endif

  // The first fetch after reset reads word 0; later ones advance and wrap.
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign next_addr = !fetched ? '0 : ((pc_plus4 == WRAP_ADDR) ? '0 : pc_plus4);

  // Step-rate counter: free runs 0..CLK_DIV-1 in run mode, parked at 0 when paused.
  always_ff @(posedge clk) begin
    if (rst || !bus.run) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; triggers outside IDLE are dropped, not queued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == 2'd0) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch datapath: address launch, latency countdown, instruction capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      lat_cnt  <= 2'd0;
      fetched  <= 1'b0;
`ifdef FETCH_BREAK_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            addr_q   <= next_addr;
            lat_cnt  <= LAT_INIT;
            fetched  <= 1'b1;
`ifdef FETCH_BREAK_EN
            halted_q <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
        end
        S_LATCH: begin
          inst_q <= bus.mem_data;
          pc_q   <= addr_q;
`ifdef FETCH_BREAK_EN
          if (bus.brk_en && (addr_q == bus.brk_addr)) halted_q <= 1'b1;
`endif
        end
        default: begin
          lat_cnt <= 2'd0;
        end
      endcase
    end
  end

  // FSM outputs: memory enable only while waiting on the ROM, strobe in LATCH.
  always_comb begin
    bus.mem_en     = (state == S_WAIT);
    bus.mem_addr   = addr_q;
    bus.pc         = pc_q;
    bus.inst       = inst_q;
    bus.inst_valid = (state == S_LATCH);
    bus.busy       = (state != S_IDLE);
    dbg_state      = state;
`ifdef FETCH_BREAK_EN
    bus.halted     = halted_q;
`endif
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Three instances share clk/rst:
//   a: CLK_DIV=4, MEM_DEPTH=4,  ROM_LAT=1 (auto-run, wrap, run/step priority,
//      breakpoint when FETCH_BREAK_EN is defined)
//   b: CLK_DIV=4, MEM_DEPTH=64, ROM_LAT=3 (single-step latency, dropped step)
//   c: CLK_DIV=4, MEM_DEPTH=64, ROM_LAT=2 (reset during WAIT)
// Each instruction ROM model is a ROM_LAT-deep pipeline returning
// 0x1000_0000 | address.
module tb_fetch_sequencer;

  localparam logic [31:0] PAT = 32'h1000_0000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) a_bus ();
  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) b_bus ();
  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) c_bus ();
  logic [1:0] a_state;
  logic [1:0] b_state;
  logic [1:0] c_state;

  fetch_sequencer #(.CLK_DIV(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(4), .ROM_LAT(1))
    u_a (.clk(clk), .rst(rst), .bus(a_bus), .dbg_state(a_state));
  fetch_sequencer #(.CLK_DIV(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(64), .ROM_LAT(3))
    u_b (.clk(clk), .rst(rst), .bus(b_bus), .dbg_state(b_state));
  fetch_sequencer #(.CLK_DIV(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(64), .ROM_LAT(2))
    u_c (.clk(clk), .rst(rst), .bus(c_bus), .dbg_state(c_state));

  // ROM models
  logic [31:0] rom_a;
  logic [31:0] rom_b [3];
  logic [31:0] rom_c [2];

  always @(posedge clk) begin
    if (a_bus.mem_en) rom_a <= PAT | a_bus.mem_addr;
  end
  always @(posedge clk) begin
    if (b_bus.mem_en) rom_b[0] <= PAT | b_bus.mem_addr;
    rom_b[1] <= rom_b[0];
    rom_b[2] <= rom_b[1];
  end
  always @(posedge clk) begin
    if (c_bus.mem_en) rom_c[0] <= PAT | c_bus.mem_addr;
    rom_c[1] <= rom_c[0];
  end
  assign a_bus.mem_data = rom_a;
  assign b_bus.mem_data = rom_b[2];
  assign c_bus.mem_data = rom_c[1];

  // Background monitors: a-address range and back-to-back strobes.
  logic       saw_high_addr = 1'b0;
  logic       saw_b2b       = 1'b0;
  logic [2:0] prev_valid    = 3'b000;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_bus.mem_addr >= 32'd16) saw_high_addr <= 1'b1;
      if (({a_bus.inst_valid, b_bus.inst_valid, c_bus.inst_valid} & prev_valid) != 3'b000)
        saw_b2b <= 1'b1;
    end
    prev_valid <= {a_bus.inst_valid, b_bus.inst_valid, c_bus.inst_valid};
  end

  // Scoreboard counters
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic valid_of(input int sel);
    case (sel)
      0:       return a_bus.inst_valid;
      1:       return b_bus.inst_valid;
      default: return c_bus.inst_valid;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return a_bus.busy;
      1:       return b_bus.busy;
      default: return c_bus.busy;
    endcase
  endfunction

  function automatic logic [31:0] pc_of(input int sel);
    case (sel)
      0:       return a_bus.pc;
      1:       return b_bus.pc;
      default: return c_bus.pc;
    endcase
  endfunction

  function automatic logic [31:0] inst_of(input int sel);
    case (sel)
      0:       return a_bus.inst;
      1:       return b_bus.inst;
      default: return c_bus.inst;
    endcase
  endfunction

  // Driver tasks
  task automatic set_step(input int sel, input logic v);
    case (sel)
      0:       a_bus.step = v;
      1:       b_bus.step = v;
      default: c_bus.step = v;
    endcase
  endtask

  // Wait (bounded) for the next strobe, then one more negedge so pc/inst settle.
  task automatic next_fetch(input int sel, input int budget, output int gap);
    logic seen;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!valid_of(sel) && gap < budget);
    seen = valid_of(sel);
    check("fetch_seen", seen, 1'b1);
    @(negedge clk);
    check("no_back_to_back", valid_of(sel), 1'b0);
  endtask

  // One step pulse, then watch win negedges; optionally re-pulse step at k=extra_at.
  task automatic step_window(input int sel, input int win, input int extra_at,
                             output int gap, output int nval, output logic [31:0] pc_after);
    set_step(sel, 1'b1);
    gap = 0;
    nval = 0;
    pc_after = '0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (k == 1) set_step(sel, 1'b0);
      if (gap != 0 && k == gap + 1) pc_after = pc_of(sel);
      if (valid_of(sel)) begin
        nval++;
        if (gap == 0) gap = k;
      end
      if (k == extra_at) begin
        check("extra_step_while_busy", busy_of(sel), 1'b1);
        set_step(sel, 1'b1);
      end
      if (k == extra_at + 1) set_step(sel, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          gap;
    int          nval;
    logic [31:0] pc_after;
    logic [31:0] exp_pc_a [4];

    rst = 1'b1;
    a_bus.run = 1'b0; a_bus.step = 1'b0;
    b_bus.run = 1'b0; b_bus.step = 1'b0;
    c_bus.run = 1'b0; c_bus.step = 1'b0;
`ifdef FETCH_BREAK_EN
    a_bus.brk_en = 1'b0; a_bus.brk_addr = 32'd8;
    b_bus.brk_en = 1'b0; b_bus.brk_addr = 32'd0;
    c_bus.brk_en = 1'b0; c_bus.brk_addr = 32'd0;
`endif
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_pc",         a_bus.pc,         32'd0);
    check("rst_mem_addr",   a_bus.mem_addr,   32'd0);
    check("rst_inst",       a_bus.inst,       32'd0);
    check("rst_inst_valid", a_bus.inst_valid, 1'b0);
    check("rst_mem_en",     a_bus.mem_en,     1'b0);
    check("rst_busy",       a_bus.busy,       1'b0);
    check("rst_state",      a_state,          2'd0);
`ifdef FETCH_BREAK_EN
    check("rst_halted",     a_bus.halted,     1'b0);
`endif
    rst = 1'b0;

    // Auto-run: first strobe after the counter reaches 3, then every 4 cycles
    a_bus.run = 1'b1;
    next_fetch(0, 20, gap);
    check("t1_first_gap",  gap,        5);
    check("t1_first_pc",   a_bus.pc,   32'd0);
    check("t1_first_inst", a_bus.inst, 32'h1000_0000);
    next_fetch(0, 20, gap);
    check("t1_period_gap", gap,        3);
    check("t1_second_pc",  a_bus.pc,   32'd4);
    check("t1_second_inst",a_bus.inst, 32'h1000_0004);

    // Wrap at MEM_DEPTH=4: 8, 12, 0, 4
    exp_pc_a[0] = 32'd8;
    exp_pc_a[1] = 32'd12;
    exp_pc_a[2] = 32'd0;
    exp_pc_a[3] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      next_fetch(0, 20, gap);
      check("t2_gap",  gap,        3);
      check("t2_pc",   a_bus.pc,   exp_pc_a[i]);
      check("t2_inst", a_bus.inst, PAT | exp_pc_a[i]);
    end
    a_bus.run = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_paused_idle", a_state, 2'd0);

    // run and step rise together, and step again on the tick cycle: one fetch
    a_bus.run  = 1'b1;
    a_bus.step = 1'b1;
    nval = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) a_bus.step = 1'b0;
      if (a_bus.inst_valid) nval++;
      if (k == 3) a_bus.step = 1'b1;
      if (k == 4) a_bus.step = 1'b0;
    end
    a_bus.run = 1'b0;
    check("t5_fetch_count", nval,       1);
    check("t5_pc",          a_bus.pc,   32'd8);
    check("t5_inst",        a_bus.inst, 32'h1000_0008);
    repeat (4) @(negedge clk);

    // Single-step with ROM_LAT=3: strobe 4 cycles after each step; extra step dropped
    for (int i = 0; i < 3; i++) begin
      step_window(1, 8, (i == 1) ? 2 : 0, gap, nval, pc_after);
      check("t3_gap",   gap,        4);
      check("t3_count", nval,       1);
      check("t3_pc",    pc_after,   32'(i * 4));
      check("t3_inst",  b_bus.inst, PAT | 32'(i * 4));
    end

    // Reset during WAIT with ROM_LAT=2
    step_window(2, 6, 0, gap, nval, pc_after);
    check("t4_gap",    gap,      3);
    check("t4_pc0",    pc_after, 32'd0);
    step_window(2, 6, 0, gap, nval, pc_after);
    check("t4_pc1",    pc_after, 32'd4);
    c_bus.step = 1'b1;
    @(negedge clk);
    c_bus.step = 1'b0;
    check("t4_in_wait", c_state, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_state",  c_state,          2'd0);
    check("t4_rst_pc",     c_bus.pc,         32'd0);
    check("t4_rst_inst",   c_bus.inst,       32'd0);
    check("t4_rst_mem_en", c_bus.mem_en,     1'b0);
    check("t4_rst_valid",  c_bus.inst_valid, 1'b0);
    rst = 1'b0;
    nval = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (c_bus.inst_valid) nval++;
    end
    check("t4_no_strobe_after_abort", nval, 0);
    step_window(2, 6, 0, gap, nval, pc_after);
    check("t4_restart_gap",  gap,        3);
    check("t4_restart_pc",   pc_after,   32'd0);
    check("t4_restart_inst", c_bus.inst, 32'h1000_0000);

`ifdef FETCH_BREAK_EN
    // Breakpoint at 8 on instance a (fresh from the reset above)
    a_bus.brk_en = 1'b1;
    a_bus.run    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_fetch(0, 20, gap);
      check("t6_pc", a_bus.pc, 32'(i * 4));
    end
    check("t6_halted", a_bus.halted, 1'b1);
    nval = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_bus.inst_valid) nval++;
    end
    check("t6_no_auto_while_halted", nval, 0);
    step_window(0, 3, 0, gap, nval, pc_after);
    check("t6_step_gap",     gap,          2);
    check("t6_step_pc",      pc_after,     32'd12);
    check("t6_step_unhalts", a_bus.halted, 1'b0);
    next_fetch(0, 20, gap);
    check("t6_resume_pc",     a_bus.pc,     32'd0);
    check("t6_resume_halted", a_bus.halted, 1'b0);
    a_bus.run = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Whole-run monitors
    check("addr_below_wrap",   saw_high_addr, 1'b0);
    check("strobe_single_cyc", saw_b2b,       1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised instruction-fetch sequencer for the single-cycle MIPS demo top level. It replaces the fixed 1 Hz divider plus free-running PC with one block that adds these controls:
- programmable step rate
- run/pause and single-step
- ROM latency handling
- address wrap at a configurable depth
It drives the instruction memory and presents a latched instruction plus valid strobe to the controller and the display.

Parameters:
CLK_DIV, 100000000, clk cycles per automatic step in run mode (>=2)
ADDR_W, 32, width of PC / memory address
DATA_W, 32, instruction width
MEM_DEPTH, 64, instruction memory depth in words (power of 2, >=2)
ROM_LAT, 1, read latency of instruction memory in clk cycles (1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
run  input  1  level; 1 = auto-step every CLK_DIV cycles, 0 = paused
step  input  1  single-cycle pulse; requests one fetch while paused
mem_en  output  1  instruction memory enable
mem_addr  output  ADDR_W  byte address to instruction memory (= pc)
mem_data  input  DATA_W  instruction memory read data
pc  output  ADDR_W  byte address of instruction held in inst
inst  output  DATA_W  latched instruction
inst_valid  output  1  one-cycle pulse when inst/pc update
busy  output  1  1 while a fetch is in flight

Behaviour:
- Reset: one clk; rst sampled on the clk edge only. Values after reset:
  - pc = 0, mem_addr = 0
  - inst = 0, inst_valid = 0, mem_en = 0, busy = 0
  - tick counter = 0, state = IDLE
- Tick counter:
  - Counts 0..CLK_DIV-1 while run=1; tick asserted on the cycle count = CLK_DIV-1, then wraps to 0.
  - Held at 0 while run=0.
- Fetch trigger:
  - run=1: trigger = tick.
  - run=0: trigger = step.
  - A step pulse while run=1 is ignored.
  - A trigger while busy=1 is dropped, never queued.
- FSM states:
  - IDLE: wait for trigger. On trigger, drive mem_addr = next address, mem_en=1, latency counter = ROM_LAT-1, go WAIT.
  - WAIT: keep mem_en=1 and mem_addr stable. Decrement the counter; when it is 0, go LATCH.
  - LATCH: inst <= mem_data, pc <= mem_addr, inst_valid=1 for this cycle, mem_en=0, go IDLE.
- Next address:
  - First fetch after reset is address 0.
  - Each later fetch uses pc+4.
  - Wrap: if pc+4 == MEM_DEPTH*4, the next address is 0. Only the low log2(MEM_DEPTH)+2 bits are ever non-zero.
- Latency: trigger to inst_valid = ROM_LAT+1 cycles.
- busy = 1 in WAIT and LATCH.
- Mid-operation events:
  - rst in any state aborts the fetch and applies reset values next edge; no inst_valid is emitted.
  - run deasserted during WAIT: the in-flight fetch completes normally.
  - run and step rising in the same cycle: run wins, step ignored.
- inst and pc hold their values between fetches.
- inst_valid is never asserted on two consecutive cycles.

Optional Feature:
Macro FETCH_BREAK_EN.
- Defined:
  - Adds input brk_addr [ADDR_W-1:0], input brk_en 1, output halted 1 (reset 0).
  - In LATCH, if brk_en=1 and the latched pc == brk_addr, set halted=1.
  - While halted=1, auto-step (run) triggers are suppressed.
  - A step pulse clears halted and performs one fetch, so execution can continue past the breakpoint.
  - rst clears halted.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
1. CLK_DIV=4, ROM_LAT=1, mem_data = addr-pattern 0x1000_0000|addr:
   - rst 2 cycles, then run=1.
   - inst_valid every 4 cycles; first pc=0 inst=0x10000000, then pc=4 inst=0x10000004.
2. MEM_DEPTH=4, run=1:
   - pc sequence 0,4,8,12,0,4.
   - mem_addr never equals 16.
3. run=0, step pulses 3, 8 cycles apart, ROM_LAT=3:
   - inst_valid appears exactly 4 cycles after each step; pc 0,4,8.
   - Extra step pulse during busy=1 produces no extra fetch.
4. ROM_LAT=2, assert rst during WAIT:
   - Next cycle state IDLE, pc=0, inst=0, mem_en=0, no inst_valid.
   - Following step fetches address 0.
5. run=1 and step=1 asserted together on the same cycle the tick fires:
   - Exactly one fetch occurs.
6. FETCH_BREAK_EN defined, brk_en=1, brk_addr=8, run=1:
   - Fetches stop after pc=8 with halted=1.
   - Step pulse gives pc=12 and halted=0; auto-run then resumes.
